mnist_frame_streamer: RTL and testbench
=======================================

MNIST_FRAME_STREAMER -- requirements
Module: mnist_frame_streamer

Interface
REQ-001 Parameter FRAME_BYTES, default 32, sets the number of image bytes per frame (16x16 binary image, 2 bytes per row, MSB-first).
REQ-002 Parameter LATENCY, default 4, sets the number of cycles from the last pixel byte to a valid classifier index.
REQ-003 Parameter INDEX_W, default 4, sets the width of the class index.
REQ-004 Port clk, input, 1, is the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1, is the reset; it SHALL be synchronous and active-high.
REQ-006 Port wr_en, input, 1, is the frame-buffer write strobe.
REQ-007 Port wr_addr, input, clog2(FRAME_BYTES), is the frame-buffer byte address.
REQ-008 Port wr_data, input, 8, is the frame-buffer write data.
REQ-009 Port start, input, 1, is the request to stream one frame.
REQ-010 Port repeat_en, input, 1, requests an automatic restart after each frame.
REQ-011 Port pixel_byte, output, 8, carries the pixel byte to the classifier ui_in.
REQ-012 Port pixel_valid, output, 1, is high while pixel_byte carries frame data.
REQ-013 Port class_in, input, INDEX_W, is the classifier result index (classifier uio_out).
REQ-014 Port busy, output, 1, is high while a frame is in flight.
REQ-015 Port done, output, 1, is a one-cycle pulse when class_out is updated.
REQ-016 Port class_out, output, INDEX_W, is the latched class index.
REQ-017 Port class_valid, output, 1, is high while class_out holds a result of the current buffer contents.

Function
REQ-018 The FSM SHALL have the states IDLE, STREAM and WAIT.
REQ-019 In IDLE, start=1 in cycle T SHALL be accepted and the FSM SHALL enter STREAM at T+1.
REQ-020 In STREAM, pixel_byte SHALL equal buffer[k] with pixel_valid=1 in cycle T+1+k, for k=0..FRAME_BYTES-1.
REQ-021 After byte FRAME_BYTES-1, the FSM SHALL spend LATENCY cycles in WAIT with pixel_valid=0 and pixel_byte=0.
REQ-022 class_in SHALL be sampled in cycle T+FRAME_BYTES+LATENCY.
REQ-023 The sampled class_in SHALL appear on class_out from cycle T+FRAME_BYTES+LATENCY+1, with done=1 for exactly that cycle and class_valid=1.
REQ-024 busy SHALL be 1 from cycle T+1 through T+FRAME_BYTES+LATENCY inclusive.
REQ-025 From the done cycle onward, the FSM SHALL be IDLE, unless repeat_en=1 in the sampling cycle, in which case the done cycle acts as cycle T of a new frame with no gap.
REQ-026 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-027 Writes SHALL be accepted only while busy=0, and writes while busy=1 SHALL be dropped.
REQ-028 A write in the same cycle as an accepted start SHALL be visible in that frame (write-first).
REQ-029 An accepted write SHALL clear class_valid in the following cycle; class_out SHALL hold its value.
REQ-030 The byte counter SHALL count 0..FRAME_BYTES-1 and SHALL NOT wrap into a second read of byte 0 within one frame.
REQ-031 The wait counter SHALL count 0..LATENCY-1.
REQ-032 LATENCY=0 SHALL sample class_in in the cycle after the last byte.

Reset
REQ-033 While rst=1, the block SHALL set FSM=IDLE and the counters to 0.
REQ-034 While rst=1, the block SHALL set pixel_byte=0, pixel_valid=0, busy=0, done=0, class_out=0 and class_valid=0.
REQ-035 rst mid-frame SHALL abort the frame with no done pulse.
REQ-036 The frame buffer SHALL NOT be cleared by rst; its contents SHALL be retained.
REQ-037 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-038 A shared package mnist_pkg SHALL hold FRAME_BYTES, INDEX_W, the default LATENCY and the state enumeration.
REQ-039 The frame buffer SHALL be one sub-module, frame_buffer_32x8: synchronous write, registered read, write-first bypass, inferable as iCE40 RAM or LUTs.
REQ-040 The block SHALL drop into the iCEBreaker top in place of the ad-hoc pattern counter, with class_out driving seven_segment.

Verification
REQ-041 Load a "0" digit image (bytes 0x00,0x00,0x00,0x00,0x03,0xE0,...) and pulse start at T -> pixel_byte sequence matches byte-for-byte at T+1..T+32; a class_in stub forced to 4'd0 at T+36 -> class_out=0, done at T+37.
REQ-042 Assert start at T+10 during a frame, and attempt a write at T+5 -> no restart, frame unchanged, buffer byte unchanged after the frame.
REQ-043 Set repeat_en=1 for 3 frames with class_in stub 3,7,9 -> three done pulses exactly 37 cycles apart, class_out 3,7,9, busy never low between frames.
REQ-044 Assert rst at T+20 -> outputs zero next cycle, no done; a new start afterwards streams the same retained buffer.
REQ-045 Write wr_addr=0, data=0xFF in the same cycle as start -> first pixel_byte=0xFF; an idle write after done -> class_valid falls, class_out holds.
REQ-046 Run with LATENCY=0 -> class_in is sampled at T+32 and done is at T+33.

Source files
------------

// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared frame geometry, classifier defaults and streamer state encoding
package mnist_pkg;

  localparam int FRAME_BYTES     = 32;
  localparam int INDEX_W         = 4;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/frame_buffer_32x8.sv
// rtl/frame_buffer_32x8.sv - byte-wide frame store, sync write, registered read with write-first bypass
module frame_buffer_32x8 #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_q;

  // No reset on purpose: image contents must survive a streamer reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= wd;
    end
    rd_q <= (we && (wa == ra)) ? wd : mem_q[ra];
  end

  assign rd = rd_q;

endmodule

// File: rtl/mnist_frame_streamer.sv
// rtl/mnist_frame_streamer.sv - streams a stored 16x16 binary frame into the classifier and latches its class index
module mnist_frame_streamer #(
  parameter int FRAME_BYTES = mnist_pkg::FRAME_BYTES,
  parameter int LATENCY     = mnist_pkg::DEFAULT_LATENCY,
  parameter int INDEX_W     = mnist_pkg::INDEX_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(FRAME_BYTES)-1:0] wr_addr,
  input  logic [7:0]                     wr_data,
  input  logic                           start,
  input  logic                           repeat_en,
  output logic [7:0]                     pixel_byte,
  output logic                           pixel_valid,
  input  logic [INDEX_W-1:0]             class_in,
  output logic                           busy,
  output logic                           done,
  output logic [INDEX_W-1:0]             class_out,
  output logic                           class_valid
);

  import mnist_pkg::*;

  localparam int AW = $clog2(FRAME_BYTES);
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [AW-1:0] LAST_BYTE = AW'(FRAME_BYTES - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_e               state_q, state_d;
  logic [AW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 restart_q, restart_d;
  logic                 done_q, done_d;
  logic                 class_valid_q, class_valid_d;
  logic [INDEX_W-1:0]   class_q, class_d;
  logic [AW-1:0]        rd_addr;
  logic [7:0]           rd_data;
  logic                 wr_ok;
  logic                 sample;

  // restart_q keeps busy high through the done cycle of a repeating frame.
  assign busy  = (state_q != ST_IDLE) || restart_q;
  assign wr_ok = wr_en && !busy;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    restart_d     = 1'b0;
    done_d        = 1'b0;
    class_d       = class_q;
    class_valid_d = class_valid_q && !wr_ok;
    rd_addr       = '0;
    sample        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start || restart_q) begin
          state_d    = ST_STREAM;
          byte_cnt_d = '0;
        end
      end
      ST_STREAM: begin
        if (byte_cnt_q == LAST_BYTE) begin
          if (LATENCY == 0) begin
            sample = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end
        end else begin
          rd_addr    = byte_cnt_q + 1'b1;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          sample = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sample) begin
      state_d       = ST_IDLE;
      class_d       = class_in;
      done_d        = 1'b1;
      class_valid_d = 1'b1;
      restart_d     = repeat_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      restart_q     <= 1'b0;
      done_q        <= 1'b0;
      class_q       <= '0;
      class_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      restart_q     <= restart_d;
      done_q        <= done_d;
      class_q       <= class_d;
      class_valid_q <= class_valid_d;
    end
  end

  frame_buffer_32x8 #(
    .DEPTH (FRAME_BYTES),
    .AW    (AW)
  ) u_buf (
    .clk (clk),
    .we  (wr_ok),
    .wa  (wr_addr),
    .wd  (wr_data),
    .ra  (rd_addr),
    .rd  (rd_data)
  );

  assign pixel_valid = (state_q == ST_STREAM);
  assign pixel_byte  = pixel_valid ? rd_data : 8'h00;
  assign done        = done_q;
  assign class_out   = class_q;
  assign class_valid = class_valid_q;

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// tb/tb_mnist_frame_streamer.sv - directed/random frame streaming checks against a byte-array reference
module tb_mnist_frame_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       repeat_en;
  logic [3:0] class_in;
  logic       use0;

  logic [7:0] pb1, pb0;
  logic       pv1, pv0, bz1, bz0, dn1, dn0, cv1, cv0;
  logic [3:0] co1, co0;

  logic [31:0] o_pb, o_pv, o_bz, o_dn, o_cv, o_co;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [32];
  logic [15:0] zero_img [16] = '{16'h0000, 16'h0000, 16'h03E0, 16'h0630,
                                  16'h0C18, 16'h0C18, 16'h0C18, 16'h0C18,
                                  16'h0C18, 16'h0C18, 16'h0630, 16'h03E0,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000};

  always #5 clk = ~clk;

  mnist_frame_streamer dut (
    .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .start (start && !use0), .repeat_en (repeat_en), .pixel_byte (pb1), .pixel_valid (pv1),
    .class_in (class_in), .busy (bz1), .done (dn1), .class_out (co1), .class_valid (cv1)
  );

  mnist_frame_streamer #(.LATENCY(0)) dut0 (
    .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .start (start && use0), .repeat_en (repeat_en), .pixel_byte (pb0), .pixel_valid (pv0),
    .class_in (class_in), .busy (bz0), .done (dn0), .class_out (co0), .class_valid (cv0)
  );

  assign o_pb = 32'(use0 ? pb0 : pb1);
  assign o_pv = 32'(use0 ? pv0 : pv1);
  assign o_bz = 32'(use0 ? bz0 : bz1);
  assign o_dn = 32'(use0 ? dn0 : dn1);
  assign o_cv = 32'(use0 ? cv0 : cv1);
  assign o_co = 32'(use0 ? co0 : co1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Entered in cycle T (start raised here if with_start); returns in the done cycle.
  task automatic do_frame(input int lat, input logic [3:0] cls, input bit rpt,
                          input bit with_start, input int wr_at, input int st_at);
    if (with_start) start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("stream_valid", o_pv, 1);
      chk($sformatf("stream_byte%0d", k), o_pb, 32'(ref_mem[k]));
      chk("stream_busy", o_bz, 1);
      chk("stream_done", o_dn, 0);
      if (k + 1 == wr_at) begin
        wr_en = 1'b1; wr_addr = 5'($urandom); wr_data = 8'($urandom);
      end
      if (k + 1 == st_at) start = 1'b1;
      if (k == 31 && lat == 0) begin
        class_in = cls; repeat_en = rpt;
      end else begin
        class_in = 4'($urandom);
      end
      tick();
      wr_en = 1'b0; start = 1'b0;
    end
    for (int w = 0; w < lat; w++) begin
      chk("wait_valid", o_pv, 0);
      chk("wait_byte", o_pb, 0);
      chk("wait_busy", o_bz, 1);
      chk("wait_done", o_dn, 0);
      if (w == lat - 1) begin
        class_in = cls; repeat_en = rpt;
      end else begin
        class_in = 4'($urandom);
      end
      tick();
    end
    repeat_en = 1'b0;
    class_in  = 4'($urandom);
    chk("done_pulse", o_dn, 1);
    chk("done_class", o_co, 32'(cls));
    chk("done_cvalid", o_cv, 1);
    chk("done_busy", o_bz, rpt ? 1 : 0);
  endtask

  initial begin
    logic [3:0] c;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    repeat_en = 1'b0; class_in = '0; use0 = 1'b0;
    tick(); tick();
    chk("rst_byte", o_pb, 0);
    chk("rst_valid", o_pv, 0);
    chk("rst_busy", o_bz, 0);
    chk("rst_done", o_dn, 0);
    chk("rst_class", o_co, 0);
    chk("rst_cvalid", o_cv, 0);
    rst = 1'b0;
    tick();

    for (int r = 0; r < 16; r++) begin
      wr_byte(5'(2 * r), zero_img[r][15:8]);
      wr_byte(5'(2 * r + 1), zero_img[r][7:0]);
    end
    do_frame(4, 4'd0, 1'b0, 1'b1, -1, -1);
    tick();
    chk("post_busy", o_bz, 0);

    c = 4'($urandom);
    do_frame(4, c, 1'b0, 1'b1, 5, 10);
    tick();
    chk("noqueue_busy", o_bz, 0);
    chk("noqueue_done", o_dn, 0);
    do_frame(4, c, 1'b0, 1'b1, -1, -1);
    tick();

    do_frame(4, 4'd3, 1'b1, 1'b1, -1, -1);
    do_frame(4, 4'd7, 1'b1, 1'b0, -1, -1);
    do_frame(4, 4'd9, 1'b0, 1'b0, -1, -1);
    tick();
    wr_byte(5'($urandom_range(1, 31)), 8'($urandom));
    chk("idlewr_cvalid", o_cv, 0);
    chk("idlewr_class", o_co, 9);

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hFF; ref_mem[0] = 8'hFF;
    do_frame(4, 4'($urandom), 1'b0, 1'b1, -1, -1);
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("abort_byte", o_pb, 0);
    chk("abort_valid", o_pv, 0);
    chk("abort_busy", o_bz, 0);
    chk("abort_done", o_dn, 0);
    chk("abort_class", o_co, 0);
    chk("abort_cvalid", o_cv, 0);
    for (int i = 0; i < 30; i++) begin
      if (o_dn !== 0 || o_bz !== 0) chk("abort_quiet", o_dn | o_bz, 0);
      tick();
    end
    do_frame(4, 4'($urandom), 1'b0, 1'b1, -1, -1);
    tick();

    for (int a = 0; a < 32; a++) wr_byte(5'(a), 8'($urandom));
    use0 = 1'b1;
    tick();
    chk("lat0_idle_busy", o_bz, 0);
    do_frame(0, 4'($urandom), 1'b0, 1'b1, -1, -1);
    tick();
    chk("lat0_post_busy", o_bz, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
